// File: rtl/obi_apb_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : obi_apb_bridge
// Description : Single-outstanding OBI-to-APB manager bridge with ACCESS-phase
//               timeout so that a silent responder cannot stall the core.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_apb_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    // OBI request / response
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,

    // APB manager
    output logic [AddrWidth-1:0]   paddr_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pready_i,
    input  logic                   pslverr_i
);

    localparam int unsigned c_strb_w = DataWidth / 8;
    localparam int unsigned c_cnt_w  = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_max   = '1;
    localparam logic [AddrWidth-1:0] c_word_mask = ~(AddrWidth'(3));

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_we;
    logic [c_strb_w-1:0]  r_be;
    logic [DataWidth-1:0] r_wdata;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_cnt;

    logic w_accept;
    logic w_in_access;
    logic w_done;
    logic w_timeout;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign gnt_o       = req_i & ((r_state == c_st_idle) | (r_state == c_st_resp));
    assign w_accept    = req_i & gnt_o;
    assign w_in_access = (r_state == c_st_access);
    assign w_done      = w_in_access & pready_i;

    // A responder answering on the terminal-count cycle still completes normally.
    generate
        if (TimeoutCycles != 0) begin : g_timeout_en
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TimeoutCycles - 1);
            assign w_timeout = w_in_access & ~pready_i & (r_cnt == c_cnt_last);
        end else begin : g_timeout_dis
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_accept) w_state_nxt = c_st_setup;
            c_st_setup:  w_state_nxt = c_st_access;
            c_st_access: if (w_done || w_timeout) w_state_nxt = c_st_resp;
            c_st_resp:   w_state_nxt = w_accept ? c_st_setup : c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture; read-side strobe/data are zeroed here so the APB
    // outputs can be driven straight from these registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= addr_i & c_word_mask;
            r_we    <= we_i;
            r_be    <= we_i ? be_i : '0;
            r_wdata <= we_i ? wdata_i : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Timeout counter: cleared on the way into SETUP, saturates rather than
    // wrapping so a disabled timeout can never alias onto a terminal count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_in_access && !pready_i && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_done) begin
            r_rdata <= r_we ? '0 : prdata_i;
            r_err   <= pslverr_i;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign psel_o    = (r_state == c_st_setup) | w_in_access;
    assign penable_o = w_in_access;
    assign paddr_o   = r_addr;
    assign pwrite_o  = r_we;
    assign pwdata_o  = r_wdata;
    assign pstrb_o   = r_be;

    assign rvalid_o  = (r_state == c_st_resp);
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_apb_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_obi_apb_bridge
// Description : Transaction-timeline reference model bench for obi_apb_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_apb_bridge;

    localparam int TC    = 8;
    localparam int NEVER = 1000000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [31:0] addr_i, wdata_i, rdata_o, paddr_o, pwdata_o, prdata_i;
    logic [3:0]  be_i, pstrb_o;
    logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;

    always #5 clk_i = ~clk_i;

    obi_apb_bridge #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (TC)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .wdata_i   (wdata_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .paddr_o   (paddr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    // w = number of wait states the responder inserts (NEVER = hung responder)
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          w;
        logic        slverr;
        logic [31:0] prdata;
    } txn_t;

    txn_t dq[$];
    txn_t pend_t, cur;
    bit   pend = 0, act = 0, rand_en = 0;
    int   n = 0, g = 0, len = 0, resp_cyc = 0;
    int   n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic we, input logic [3:0] be,
                                input logic [31:0] wd, input int w, input logic se,
                                input logic [31:0] rd);
        txn_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd;
        t.w = w; t.slverr = se; t.prdata = rd;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int r;
        r = $urandom_range(0, 19);
        return mk($urandom, 1'($urandom), 4'($urandom), $urandom,
                  (r < 12) ? $urandom_range(0, 3) : (r < 17) ? $urandom_range(4, 9) : NEVER,
                  ($urandom_range(0, 3) == 0), $urandom);
    endfunction

    // One clock cycle: drive after the rising edge, check at the falling edge.
    task automatic run_cycle();
        bit can_grant, exp_gnt, in_setup, in_acc, done_now, exp_rv, tout;
        int k;
        @(posedge clk_i);
        #1;
        n++;
        if (act && n > resp_cyc) act = 0;
        if (!pend) begin
            if (dq.size() > 0) begin
                pend_t = dq.pop_front();
                pend   = 1;
            end else if (rand_en && $urandom_range(0, 2) == 0) begin
                pend_t = rand_txn();
                pend   = 1;
            end
        end
        can_grant = !act || (n == resp_cyc);
        exp_gnt   = pend && can_grant;
        req_i     = pend;
        if (pend) begin
            addr_i = pend_t.addr; we_i = pend_t.we; be_i = pend_t.be; wdata_i = pend_t.wdata;
        end else begin
            addr_i = $urandom; we_i = 1'($urandom); be_i = 4'($urandom); wdata_i = $urandom;
        end
        in_setup  = act && (n == g + 1);
        in_acc    = act && (n >= g + 2) && (n <= g + 1 + len);
        k         = n - g - 2;
        exp_rv    = act && (n == resp_cyc);
        done_now  = in_acc && (k == cur.w);
        pready_i  = in_acc ? done_now : 1'($urandom);
        pslverr_i = done_now ? cur.slverr : 1'($urandom);
        prdata_i  = done_now ? cur.prdata : $urandom;

        @(negedge clk_i);
        check("gnt", gnt_o, exp_gnt);
        check("psel", psel_o, in_setup || in_acc);
        check("penable", penable_o, in_acc);
        check("rvalid", rvalid_o, exp_rv);
        if (in_setup || in_acc) begin
            check("paddr", paddr_o, cur.addr & 32'hFFFF_FFFC);
            check("pwrite", pwrite_o, cur.we);
            check("pwdata", pwdata_o, cur.we ? cur.wdata : 32'h0);
            check("pstrb", pstrb_o, cur.we ? cur.be : 4'h0);
        end
        if (exp_rv) begin
            tout = (cur.w >= TC);
            check("rdata", rdata_o, (tout || cur.we) ? 32'h0 : cur.prdata);
            check("err", err_o, tout ? 1'b1 : cur.slverr);
        end
        if (exp_gnt) begin
            cur      = pend_t;
            g        = n;
            len      = (cur.w >= TC) ? TC : cur.w + 1;
            resp_cyc = g + 2 + len;
            act      = 1;
            pend     = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (act || pend || dq.size() > 0); i++) run_cycle();
        check("drain_bound", {30'h0, act, pend}, 32'h0);
    endtask

    initial begin
        bit seen;
        req_i = 0; addr_i = 0; we_i = 0; be_i = 0; wdata_i = 0;
        prdata_i = 0; pready_i = 0; pslverr_i = 0;

        // Outputs under reset
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", gnt_o, 0);
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_pwrite", pwrite_o, 0);
        check("rst_paddr", paddr_o, 0);
        check("rst_pwdata", pwdata_o, 0);
        check("rst_pstrb", pstrb_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Idle period: psel must stay low
        repeat (10) run_cycle();

        // Directed transfers, presented back to back
        dq.push_back(mk(32'h0002_0004, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hCAFE_BABE));
        dq.push_back(mk(32'h0000_0103, 1'b1, 4'b0101, 32'h1234_5678, 4, 1'b0, 32'hDEAD_BEEF));
        dq.push_back(mk(32'h0000_0200, 1'b0, 4'hF, 32'h0, 0, 1'b1, 32'h1111_2222));
        dq.push_back(mk(32'h0000_0204, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h3333_4444));
        dq.push_back(mk(32'h0000_0300, 1'b0, 4'hF, 32'h0, NEVER, 1'b0, 32'h5555_6666));
        dq.push_back(mk(32'h0000_0304, 1'b0, 4'hF, 32'h0, TC - 1, 1'b0, 32'h7777_8888));
        dq.push_back(mk(32'h0000_0400, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hA000_0001));
        dq.push_back(mk(32'h0000_0404, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hA000_0002));
        dq.push_back(mk(32'h0000_0408, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hA000_0003));
        drain();

        // Random traffic
        rand_en = 1;
        repeat (3000) run_cycle();
        rand_en = 0;
        drain();

        // Reset during ACCESS: bus drops at once, no response afterwards
        dq.push_back(mk(32'h0000_1008, 1'b0, 4'hF, 32'h0, NEVER, 1'b0, 32'h0));
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            run_cycle();
            if (act && n >= g + 2) seen = 1;
        end
        check("reach_access", seen, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_psel", psel_o, 0);
        check("async_penable", penable_o, 0);
        check("async_rvalid", rvalid_o, 0);
        act = 0;
        pend = 0;
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (15) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
